addsub_issue: RTL and testbench
===============================

// Module: addsub_issue
// PURPOSE
//  Issue and writeback stage placed directly upstream of the two-unit ADD_SUB block.
//  - Accepts add/sub requests from decode over a valid/ready handshake.
//  - Holds operands and mode stable for ADD_SUB and pulses start.
//  - Selects unit 0/1 round-robin via use_part.
//  - Captures done/res and returns the result with its destination tag to writeback under backpressure.
//  - One operation in flight: the two units share the operand bus.
// PARAMETERS
//  TAG_W    5   destination register tag width
//  TIMEOUT  8   cycles in WAIT without done before abort with error (>=4)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  req_valid  in   1      decode request valid
//  req_ready  out  1      stage can accept a request
//  req_op1    in   32     operand 1
//  req_op2    in   32     operand 2
//  req_mode1  in   2      op_mode1 passthrough
//  req_mode2  in   3      op_mode2; bit2=1 selects subtract
//  req_tag    in   TAG_W  destination tag
//  kill       in   1      synchronous flush of the in-flight op
//  as_op1     out  32     ADD_SUB op1
//  as_op2     out  32     ADD_SUB op2
//  as_start   out  1      ADD_SUB start, single-cycle pulse
//  as_use     out  2      ADD_SUB use_part: 01 = unit0, 10 = unit1, 00 = idle/clear
//  as_mode1   out  2      ADD_SUB op_mode1
//  as_mode2   out  3      ADD_SUB op_mode2
//  as_done    in   1      ADD_SUB done
//  as_res     in   32     ADD_SUB res
//  wb_valid   out  1      result valid
//  wb_ready   in   1      writeback accepts
//  wb_data    out  32     result
//  wb_tag     out  TAG_W  tag of result
//  err        out  1      one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE.
//    - All outputs 0 except req_ready=1 while rst is high and IDLE.
//    - Round-robin pointer = unit0.
//  - FSM states, one transition per clk:
//    - IDLE: req_ready=1, as_use=00. On req_valid: latch op1/op2/mode1/mode2/tag into the hold register; go to ISSUE.
//    - ISSUE: as_start=1 for exactly this cycle; as_use = pointer code; go to WAIT; timer=0.
//    - WAIT: as_use held at pointer code; as_op*/as_mode* held.
//      - as_done=1: capture as_res into wb_data; go to WB; toggle pointer.
//      - timer==TIMEOUT-1 without done: err=1; go to DRAIN.
//    - WB: wb_valid=1 with wb_data/wb_tag held stable until wb_ready. On wb_valid&&wb_ready: go to DRAIN.
//    - DRAIN: as_use=00 for one cycle to clear unit enables; go to IDLE.
//  - Latency: accept@T, start@T+1, done@T+4 (ADD_SUB 3-cycle path), wb_valid@T+5.
//    - Handshake costs no extra cycles; next accept at earliest T+7 with wb_ready=1.
//  - as_done is ignored outside WAIT; repeat done pulses from an enabled unit are ignored.
//  - Operand hold register is written only on accept, so as_op1/as_op2 never change between ISSUE and DRAIN.
//  - kill in ISSUE/WAIT/WB: drop the op, no wb_valid, go to DRAIN; pointer not toggled.
//  - kill in IDLE/DRAIN: no effect.
//  - kill and as_done in the same cycle: kill wins.
//  - req_ready=0 in every state except IDLE; no skid buffering.
//  - Reset asserted mid-operation: immediate return to IDLE.
//    - wb_valid, as_start, as_use forced 0; the pending result is lost.
// STRUCTURE
//  - Shared package addsub_pkg:
//    - localparams USE_U0=2'b01, USE_U1=2'b10, USE_NONE=2'b00, MODE2_SUB_BIT=2.
//    - State encoding IDLE/ISSUE/WAIT/WB/DRAIN.
//  - Sub-module: addsub_issue_timer (TIMEOUT counter: clear, enable, expire).
//  - FSM, hold register and round-robin pointer stay in the top level.
// TESTING
//  - add: op1=5, op2=7, mode2=000, tag=3
//    -> as_start one pulse, as_use=01, wb_data=12, wb_tag=3 at T+5.
//  - sub back-to-back: 10-3 then 3-10 (mode2=100)
//    -> as_use 01 then 10; wb_data 7 then 0xFFFFFFF9.
//  - backpressure: wb_ready=0 for 4 cycles
//    -> wb_valid/wb_data stable throughout, req_ready=0; accept completes when wb_ready rises.
//  - timeout: as_done tied 0
//    -> err pulses at WAIT+8, no wb_valid, as_use=00 next cycle, req_ready=1 after.
//  - kill in WAIT with as_done=1 same cycle
//    -> no wb_valid, pointer unchanged, next op uses same unit.
//  - async reset in WB
//    -> wb_valid, as_start, as_use drop to 0 without a clock edge; IDLE after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the ADD_SUB issue stage.
package addsub_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MODE1_W = 2;
  localparam int unsigned MODE2_W = 3;

  localparam logic [1:0] USE_U0   = 2'b01;
  localparam logic [1:0] USE_U1   = 2'b10;
  localparam logic [1:0] USE_NONE = 2'b00;

  localparam int unsigned MODE2_SUB_BIT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Operand/mode bundle held for ADD_SUB while an op is in flight
  typedef struct packed {
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;
    logic [MODE1_W-1:0] mode1;
    logic [MODE2_W-1:0] mode2;
  } op_t;

  // Unit-select code for the round-robin pointer (0 -> unit0, 1 -> unit1)
  function automatic logic [1:0] use_code(input logic ptr);
    return ptr ? USE_U1 : USE_U0;
  endfunction

endpackage

// File: rtl/addsub_issue_timer.sv
// WAIT-state watchdog: counts enabled cycles, flags the last allowed one.
module addsub_issue_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  // Cycle counter; saturates at the expiry value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/addsub_issue.sv
// Issue/writeback stage in front of the two-unit ADD_SUB block.
module addsub_issue
  import addsub_pkg::*;
#(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DATA_W-1:0]  req_op1,
  input  logic [DATA_W-1:0]  req_op2,
  input  logic [MODE1_W-1:0] req_mode1,
  input  logic [MODE2_W-1:0] req_mode2,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               kill,
  output logic [DATA_W-1:0]  as_op1,
  output logic [DATA_W-1:0]  as_op2,
  output logic               as_start,
  output logic [1:0]         as_use,
  output logic [MODE1_W-1:0] as_mode1,
  output logic [MODE2_W-1:0] as_mode2,
  input  logic               as_done,
  input  logic [DATA_W-1:0]  as_res,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [DATA_W-1:0]  wb_data,
  output logic [TAG_W-1:0]   wb_tag,
  output logic               err
);

  state_e           state_q;
  state_e           state_d;
  op_t              hold_q;
  logic [TAG_W-1:0] tag_q;
  logic             ptr_q;

  logic hold_we;
  logic res_we;
  logic ptr_toggle;
  logic err_d;
  logic timer_clr;
  logic timer_en;
  logic timer_expire_c;

  addsub_issue_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .en       (timer_en),
    .expire_c (timer_expire_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; kill takes priority over done
  always_comb begin
    state_d    = state_q;
    hold_we    = 1'b0;
    res_we     = 1'b0;
    ptr_toggle = 1'b0;
    err_d      = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          hold_we = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr = 1'b1;
        state_d   = kill ? DRAIN : WAIT;
      end
      WAIT: begin
        if (kill) begin
          state_d = DRAIN;
        end else if (as_done) begin
          res_we     = 1'b1;
          ptr_toggle = 1'b1;
          state_d    = WB;
        end else if (timer_expire_c) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          timer_en = 1'b1;
        end
      end
      WB: begin
        if (kill || wb_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold register, result capture, pointer and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q   <= '0;
      tag_q    <= '0;
      wb_data  <= '0;
      ptr_q    <= 1'b0;
      as_start <= 1'b0;
      as_use   <= USE_NONE;
      wb_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (hold_we) begin
        hold_q <= '{op1: req_op1, op2: req_op2, mode1: req_mode1, mode2: req_mode2};
        tag_q  <= req_tag;
      end
      if (res_we) begin
        wb_data <= as_res;
      end
      if (ptr_toggle) begin
        ptr_q <= ~ptr_q;
      end
      as_start <= (state_d == ISSUE);
      wb_valid <= (state_d == WB);
      err      <= err_d;
      case (state_d)
        ISSUE:   as_use <= use_code(ptr_q);
        WAIT,
        WB:      as_use <= as_use;
        default: as_use <= USE_NONE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && rst;
  assign as_op1    = hold_q.op1;
  assign as_op2    = hold_q.op2;
  assign as_mode1  = hold_q.mode1;
  assign as_mode2  = hold_q.mode2;
  assign wb_tag    = tag_q;

endmodule

// File: tb/tb_addsub_issue.sv
// Directed bench for addsub_issue with a behavioural 3-cycle ADD_SUB model.
module tb_addsub_issue;

  localparam int unsigned TAG_W   = 5;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_op1 = '0;
  logic [31:0]       req_op2 = '0;
  logic [1:0]        req_mode1 = '0;
  logic [2:0]        req_mode2 = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              kill = 1'b0;
  logic [31:0]       as_op1;
  logic [31:0]       as_op2;
  logic              as_start;
  logic [1:0]        as_use;
  logic [1:0]        as_mode1;
  logic [2:0]        as_mode2;
  logic              as_done;
  logic [31:0]       as_res = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b1;
  logic [31:0]       wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic              err;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic model_en   = 1'b1;
  logic done_force = 1'b0;
  logic model_done = 1'b0;
  int   dly        = 0;

  always #5 clk = ~clk;

  addsub_issue #(
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_mode1 (req_mode1),
    .req_mode2 (req_mode2),
    .req_tag   (req_tag),
    .kill      (kill),
    .as_op1    (as_op1),
    .as_op2    (as_op2),
    .as_start  (as_start),
    .as_use    (as_use),
    .as_mode1  (as_mode1),
    .as_mode2  (as_mode2),
    .as_done   (as_done),
    .as_res    (as_res),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_tag    (wb_tag),
    .err       (err)
  );

  // ADD_SUB model: done/res appear three cycles after the start cycle
  assign as_done = model_done | done_force;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (as_start) begin
      dly <= 2;
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1 && model_en) begin
        model_done <= 1'b1;
        as_res     <= as_mode2[2] ? (as_op1 - as_op2) : (as_op1 + as_op2);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request from IDLE, check the ISSUE cycle, return at the first WAIT cycle
  task automatic send(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] m1, input logic [2:0] m2, input logic [TAG_W-1:0] t,
                      input logic [1:0] exp_use, input bit push);
    exp_t e;
    check({nm, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op1 = a; req_op2 = b; req_mode1 = m1; req_mode2 = m2; req_tag = t;
    if (push) begin
      e.data = m2[2] ? (a - b) : (a + b);
      e.tag  = t;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0; req_op1 = 32'hDEAD_BEEF; req_op2 = 32'hFEED_F00D;
    check({nm, ".start"}, 64'(as_start), 64'd1);
    check({nm, ".use"}, 64'(as_use), 64'(exp_use));
    check({nm, ".ops"}, {as_op1, as_op2}, {a, b});
    check({nm, ".modes"}, 64'({as_mode1, as_mode2}), 64'({m1, m2}));
    check({nm, ".rdy_busy"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    check({nm, ".start_pulse"}, 64'(as_start), 64'd0);
  endtask

  // Wait (bounded) for wb_valid, check latency and pop/compare the scoreboard
  task automatic wait_wb(input string nm, input int exp_lat, output exp_t e);
    int n = 0;
    while (!wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, ".wb_lat"}, 64'(n), 64'(exp_lat));
    e = '0;
    if (sb.size() == 0) begin
      check({nm, ".sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({nm, ".wb_data"}, 64'(wb_data), 64'(e.data));
      check({nm, ".wb_tag"}, 64'(wb_tag), 64'(e.tag));
    end
  endtask

  // DRAIN cycle then IDLE cycle after a handshake or abort
  task automatic drain_idle(input string nm);
    @(negedge clk);
    check({nm, ".drain"}, 64'({wb_valid, as_use, req_ready}), 64'd0);
    @(negedge clk);
    check({nm, ".idle"}, 64'({req_ready, as_use, as_start}), 64'b1000);
  endtask

  initial begin
    exp_t e;
    int   n;
    bit   saw_wb;

    // Reset state
    #12;
    check("rst.outs", 64'({req_ready, as_start, as_use, wb_valid, err}), 64'd0);
    check("rst.data", {as_op1, wb_data}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.release_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Add 5+7, tag 3, unit0
    send("add", 32'd5, 32'd7, 2'b00, 3'b000, 5'd3, 2'b01, 1'b1);
    wait_wb("add", 3, e);
    drain_idle("add");

    // Back-to-back subtracts alternate units
    send("sub1", 32'd10, 32'd3, 2'b11, 3'b100, 5'd4, 2'b10, 1'b1);
    wait_wb("sub1", 3, e);
    drain_idle("sub1");
    send("sub2", 32'd3, 32'd10, 2'b01, 3'b100, 5'd5, 2'b01, 1'b1);
    wait_wb("sub2", 3, e);
    check("sub2.neg", 64'(wb_data), 64'hFFFF_FFF9);
    drain_idle("sub2");

    // Backpressure: wb_ready low for 4 cycles
    wb_ready = 1'b0;
    send("bp", 32'd100, 32'd23, 2'b10, 3'b001, 5'd9, 2'b10, 1'b1);
    wait_wb("bp", 3, e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp.hold", {wb_valid, req_ready, 30'd0, wb_data}, {1'b1, 1'b0, 30'd0, e.data});
      check("bp.tag", 64'(wb_tag), 64'(e.tag));
    end
    wb_ready = 1'b1;
    drain_idle("bp");

    // Timeout: model never answers
    model_en = 1'b0;
    send("tmo", 32'd1, 32'd2, 2'b00, 3'b000, 5'd11, 2'b01, 1'b0);
    n = 0;
    saw_wb = 1'b0;
    while (!err && n < 20) begin
      @(negedge clk);
      n++;
      if (wb_valid) saw_wb = 1'b1;
    end
    check("tmo.err_lat", 64'(n), 64'd8);
    check("tmo.no_wb", 64'(saw_wb), 64'd0);
    check("tmo.use_clear", 64'(as_use), 64'd0);
    @(negedge clk);
    check("tmo.after", 64'({err, req_ready}), 64'b01);
    model_en = 1'b1;

    // Kill in WAIT in the same cycle as done: pointer stays on unit0
    send("kill", 32'd1, 32'd1, 2'b00, 3'b000, 5'd12, 2'b01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("kill.done_seen", 64'(as_done), 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill.drain", 64'({wb_valid, as_use}), 64'd0);
    @(negedge clk);
    check("kill.idle", 64'({wb_valid, req_ready}), 64'b01);

    // done and kill in IDLE have no effect
    done_force = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    kill = 1'b0;
    check("idle.ignore", 64'({wb_valid, err, req_ready}), 64'b001);
    @(negedge clk);
    check("idle.ignore2", 64'({wb_valid, as_start, req_ready}), 64'b001);

    send("after_kill", 32'd2, 32'd2, 2'b00, 3'b000, 5'd7, 2'b01, 1'b1);
    wait_wb("after_kill", 3, e);
    drain_idle("after_kill");

    // Async reset while in WB
    wb_ready = 1'b0;
    send("rstwb", 32'd50, 32'd8, 2'b00, 3'b100, 5'd17, 2'b10, 1'b1);
    wait_wb("rstwb", 3, e);
    #2;
    rst = 1'b0;
    #1;
    check("rstwb.async", 64'({wb_valid, as_start, as_use, req_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    #1;
    check("rstwb.idle", 64'({req_ready, wb_valid}), 64'b10);
    @(negedge clk);

    send("post_rst", 32'd9, 32'd9, 2'b00, 3'b000, 5'd31, 2'b01, 1'b1);
    wait_wb("post_rst", 3, e);
    drain_idle("post_rst");
    check("sb.empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
